// File: rtl/ps2_kb_rx_if.sv
// ps2_kb_rx_if: CPU data-bus port of the PS/2 keyboard peripheral.
interface ps2_kb_rx_if;
    logic [63:0] addr, wdata, rdata;
    logic rd_en, wr_en, irq;
    modport master(output addr, rd_en, wr_en, wdata, input rdata, irq);
    modport slave(input addr, rd_en, wr_en, wdata, output rdata, irq);
endinterface

// File: rtl/ps2_kb_rx.sv
// ps2_kb_rx: PS/2 device-to-host receiver with scan-code FIFO and DATA/STATUS MMIO registers.
module ps2_kb_rx #(
    parameter logic [63:0] BASE_ADDR = 64'h2000_0018,
    parameter int FIFO_DEPTH = 8,
    parameter int TIMEOUT_CYCLES = 20000
) (
    input logic clk,
    input logic rst,
    input logic ps2_clk,
    input logic ps2_data,
    ps2_kb_rx_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;
    state_t state, state_n;
    logic [1:0] clk_sync, data_sync;
    logic clk_prev, fall, bit_val, frame_ok, push, err_set, ovf_set, pop, wr_stat, full, valid;
    logic [3:0] bit_cnt;
    logic [9:0] sr;
    logic [TW-1:0] tcnt;
    logic [7:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0] cnt;
    logic ovf_sticky, err_sticky, ie, irq_q, unused_bits;
    assign fall = clk_prev & ~clk_sync[1];
    assign bit_val = data_sync[1];
    // sr holds {stop, parity, data[7:0]} once the stop bit has been shifted in
    assign frame_ok = sr[9] & ^sr[8:0];
    always_comb begin
        state_n = IDLE;
        push = 1'b0;
        err_set = 1'b0;
        if (state == IDLE)
            state_n = fall && !bit_val ? SHIFT : IDLE;
        else if (state == SHIFT)
            state_n = fall ? (bit_cnt == 4'd10 ? CHECK : SHIFT) : (tcnt == TW'(TIMEOUT_CYCLES) ? IDLE : SHIFT);
        else begin
            push = frame_ok;
            err_set = ~frame_ok;
        end
    end
    assign valid = cnt != '0;
    assign full = cnt == (AW+1)'(FIFO_DEPTH);
    assign pop = bus.rd_en && bus.addr == BASE_ADDR && valid;
    assign wr_stat = bus.wr_en && bus.addr == BASE_ADDR + 64'd4;
    // a pop in the same cycle frees a slot, so a full FIFO can still accept
    assign ovf_set = push & full & ~pop;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            clk_sync <= 2'b11;
            data_sync <= 2'b11;
            clk_prev <= 1'b1;
            state <= IDLE;
            bit_cnt <= '0;
            sr <= '0;
            tcnt <= '0;
            wp <= '0;
            rp <= '0;
            cnt <= '0;
            ovf_sticky <= 1'b0;
            err_sticky <= 1'b0;
            ie <= 1'b0;
            irq_q <= 1'b0;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
            clk_prev <= clk_sync[1];
            state <= state_n;
            bit_cnt <= state == IDLE ? 4'd1 : state == SHIFT && fall ? bit_cnt + 4'd1 : bit_cnt;
            sr <= state == SHIFT && fall ? {bit_val, sr[9:1]} : sr;
            tcnt <= state != SHIFT || fall ? '0 : tcnt + TW'(1);
            wp <= wp + AW'(push & ~ovf_set);
            rp <= rp + AW'(pop);
            cnt <= cnt + (AW+1)'(push & ~ovf_set) - (AW+1)'(pop);
            ovf_sticky <= ovf_set | (ovf_sticky & ~(wr_stat & bus.wdata[1]));
            err_sticky <= err_set | (err_sticky & ~(wr_stat & bus.wdata[2]));
            ie <= wr_stat ? bus.wdata[3] : ie;
            irq_q <= ie & valid;
        end
    always_ff @(posedge clk)
        if (push & ~ovf_set) mem[wp] <= sr[7:0];
    assign bus.rdata = bus.addr == BASE_ADDR ? {56'b0, valid ? mem[rp] : 8'h00}
                     : bus.addr == BASE_ADDR + 64'd4 ? {60'b0, ie, err_sticky, ovf_sticky, valid} : '0;
    assign bus.irq = irq_q;
    assign unused_bits = &{1'b0, bus.wdata[63:4], bus.wdata[0]};
endmodule

// File: tb/tb_ps2_kb_rx.sv
// tb_ps2_kb_rx: directed and randomized PS/2 frames checked against a queue-based model of the peripheral.
module tb_ps2_kb_rx;
    localparam logic [63:0] BASE = 64'h2000_0018;
    localparam logic [63:0] STAT = BASE + 64'd4;
    localparam int DEPTH = 8;
    localparam int TO = 2000;
    logic clk = 1'b0, rst = 1'b1, ps2_clk = 1'b1, ps2_data = 1'b1;
    int checks = 0, errors = 0;
    logic [7:0] q[$];
    logic m_ie = 1'b0, m_err = 1'b0, m_ovf = 1'b0;
    logic [63:0] rv;
    logic [7:0] rnd_b;
    int kind;
    bit found;
    ps2_kb_rx_if bus();
    ps2_kb_rx #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .bus(bus)
    );
    always #5 clk = ~clk;
    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    function automatic logic [63:0] exp_st();
        return {60'b0, m_ie, m_err, m_ovf, q.size() != 0};
    endfunction
    // frame = {stop, odd parity, data, start}, optionally corrupted
    function automatic logic [10:0] mk(logic [7:0] d, bit par_bad, bit stop_bad);
        return {~stop_bad, (~^d) ^ par_bad, d, 1'b0};
    endfunction
    // leaves ps2_clk low right after the last falling edge
    task automatic ps2_bits(logic [10:0] b, int n);
        for (int i = 0; i < n; i++) begin
            ps2_clk = 1'b1;
            ps2_data = b[i];
            #100 ps2_clk = 1'b0;
            if (i < n - 1) #100;
        end
    endtask
    task automatic send(logic [7:0] d, bit par_bad, bit stop_bad);
        ps2_bits(mk(d, par_bad, stop_bad), 11);
        #100 ps2_clk = 1'b1;
        ps2_data = 1'b1;
        repeat (10) @(negedge clk);
        if (par_bad || stop_bad) m_err = 1'b1;
        else if (q.size() == DEPTH) m_ovf = 1'b1;
        else q.push_back(d);
    endtask
    task automatic rd(logic [63:0] a, output logic [63:0] v);
        @(negedge clk);
        bus.addr = a;
        #1 v = bus.rdata;
    endtask
    task automatic pop_chk(string tag);
        @(negedge clk);
        bus.addr = BASE;
        bus.rd_en = 1'b1;
        #1 check(tag, bus.rdata, q.size() != 0 ? {56'b0, q[0]} : 64'd0);
        if (q.size() != 0) q.delete(0);
        @(negedge clk);
        bus.rd_en = 1'b0;
    endtask
    task automatic wr_stat(logic [63:0] d);
        @(negedge clk);
        bus.addr = STAT;
        bus.wdata = d;
        bus.wr_en = 1'b1;
        @(negedge clk);
        bus.wr_en = 1'b0;
        m_ie = d[3];
        if (d[1]) m_ovf = 1'b0;
        if (d[2]) m_err = 1'b0;
    endtask
    task automatic chk_regs(string tag);
        logic [63:0] v;
        rd(STAT, v);
        check({tag, "_status"}, v, exp_st());
        rd(BASE, v);
        check({tag, "_data"}, v, q.size() != 0 ? {56'b0, q[0]} : 64'd0);
        check({tag, "_irq"}, bus.irq, m_ie && q.size() != 0);
    endtask
    initial begin
        bus.addr = BASE;
        bus.rd_en = 1'b0;
        bus.wr_en = 1'b0;
        bus.wdata = '0;
        repeat (3) @(negedge clk);
        check("rst_data", bus.rdata, 64'd0);
        bus.addr = STAT;
        #1 check("rst_status", bus.rdata, 64'd0);
        check("rst_irq", bus.irq, 1'b0);
        rst = 1'b0;
        send(8'h1C, 0, 0);
        rd(STAT, rv);
        check("f1c_status_lit", rv, 64'h1);
        chk_regs("f1c");
        pop_chk("f1c_pop");
        chk_regs("f1c_after");
        send(8'h1C, 1, 0);
        rd(STAT, rv);
        check("par_err_lit", rv, 64'h4);
        chk_regs("par_err");
        wr_stat(64'h4);
        chk_regs("par_clr");
        send(8'h1C, 0, 1);
        chk_regs("stop_err");
        wr_stat(64'h4);
        chk_regs("stop_clr");
        for (int i = 1; i <= 9; i++) send(8'(i), 0, 0);
        rd(STAT, rv);
        check("ovf_status_lit", rv, 64'h3);
        chk_regs("ovf");
        for (int i = 0; i < 8; i++) pop_chk("ovf_pop");
        rd(STAT, rv);
        check("ovf_empty_lit", rv, 64'h2);
        wr_stat(64'h2);
        chk_regs("ovf_clr");
        ps2_bits(mk(8'h3C, 0, 0), 5);
        #100 ps2_clk = 1'b1;
        ps2_data = 1'b1;
        repeat (TO + 2) @(negedge clk);
        send(8'h55, 0, 0);
        chk_regs("timeout");
        pop_chk("timeout_pop");
        wr_stat(64'h8);
        ps2_bits(mk(8'hF0, 0, 0), 11);
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            bus.addr = STAT;
            #1 if (bus.rdata[0]) found = 1'b1;
        end
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        check("irq_valid_seen", found, 1'b1);
        check("irq_lag", bus.irq, 1'b0);
        @(negedge clk);
        check("irq_rise", bus.irq, 1'b1);
        bus.addr = BASE;
        bus.rd_en = 1'b1;
        #1 check("irq_data", bus.rdata, 64'hF0);
        @(negedge clk);
        bus.rd_en = 1'b0;
        #1 check("irq_hold", bus.irq, 1'b1);
        check("irq_empty", bus.rdata, 64'd0);
        @(negedge clk);
        check("irq_fall", bus.irq, 1'b0);
        send(8'h11, 0, 0);
        ps2_bits(mk(8'h99, 0, 0), 6);
        @(negedge clk);
        rst = 1'b1;
        bus.addr = BASE;
        #1 check("midrst_data", bus.rdata, 64'd0);
        bus.addr = STAT;
        #1 check("midrst_status", bus.rdata, 64'd0);
        check("midrst_irq", bus.irq, 1'b0);
        q.delete();
        m_ie = 1'b0;
        m_err = 1'b0;
        m_ovf = 1'b0;
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        send(8'hAA, 0, 0);
        chk_regs("rst_aa");
        pop_chk("rst_aa_pop");
        chk_regs("rst_one");
        pop_chk("empty_pop");
        chk_regs("empty_after");
        send(8'h33, 0, 0);
        pop_chk("after_empty_pop");
        for (int k = 0; k < 24; k++) begin
            rnd_b = 8'($urandom);
            kind = $urandom_range(0, 5);
            send(rnd_b, kind == 4, kind == 5);
            if ($urandom_range(0, 1) == 1) pop_chk("rnd_pop");
            if (kind == 3) wr_stat(64'($urandom_range(0, 15)));
            chk_regs("rnd");
        end
        while (q.size() != 0) pop_chk("drain");
        chk_regs("final");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
